// File: rtl/flash_ctrl_pkg.sv
// Shared constants and types for the flash controller page-buffer datapath.
package flash_ctrl_pkg;

    localparam int BUF_ADDR_W = 11;
    localparam int BUF_DATA_W = 8;
    localparam int BUF_DEPTH  = 2048;
    localparam int MAX_LEN    = 2048;
    localparam int LEN_W      = 12;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_DRAIN = 2'd2,
        RD_DONE  = 2'd3
    } rd_state_e;

    // A burst can never exceed one full page.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    endfunction

endpackage

// File: rtl/page_buf_reader_if.sv
// Bundle of the control, buffer read port and byte stream of the page-buffer reader.
interface page_buf_reader_if
    import flash_ctrl_pkg::*;
#(
    parameter int ADDR_W = BUF_ADDR_W,
    parameter int DATA_W = BUF_DATA_W
) ();

    logic              Start;
    logic [ADDR_W-1:0] StartAddr;
    logic [LEN_W-1:0]  Length;
    logic              Busy;
    logic              Done;
    logic [ADDR_W-1:0] BufAddr;
    logic              BufClockEn;
    logic              BufWr;
    logic [DATA_W-1:0] BufQ;
    logic [DATA_W-1:0] DataOut;
    logic              DataValid;
    logic              DataReady;

    // Byte stream: a byte moves when DataValid && DataReady on a rising edge; once
    // DataValid is high it stays high with DataOut stable until that transfer happens.
    modport master (
        input  Start, StartAddr, Length, BufQ, DataReady,
        output Busy, Done, BufAddr, BufClockEn, BufWr, DataOut, DataValid
    );

    modport slave (
        output Start, StartAddr, Length, BufQ, DataReady,
        input  Busy, Done, BufAddr, BufClockEn, BufWr, DataOut, DataValid
    );

endinterface

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO catching buffer read data; push and pop in one cycle is legal even when full.
module rd_skid_fifo #(
    parameter int DATA_W = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/page_buf_reader.sv
// Streams a burst of bytes out of the page buffer toward the NAND I/O stage,
// throttling reads so the two-entry FIFO can never overflow.
module page_buf_reader
    import flash_ctrl_pkg::*;
#(
    parameter int ADDR_W = BUF_ADDR_W,
    parameter int DATA_W = BUF_DATA_W,
    parameter int DEPTH  = BUF_DEPTH
) (
    input  logic      Clock,
    input  logic      Reset,
    page_buf_reader_if.master bus,
    output rd_state_e dbg_state
);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              inflight_q, inflight_d;

    logic              issue;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [1:0]        occ;
    logic [2:0]        outstanding;

    rd_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
        .Clock     (Clock),
        .Reset     (Reset),
        .push      (inflight_q),
        .push_data (bus.BufQ),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= RD_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        inflight_d  = issue;
        case (state_q)
            RD_IDLE: begin
                if (bus.Start) begin
                    addr_d      = bus.StartAddr;
                    remaining_d = clamp_len(bus.Length);
                    state_d     = (bus.Length == '0) ? RD_DONE : RD_RUN;
                end
            end
            RD_RUN: begin
                if (issue) begin
                    addr_d      = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = RD_DRAIN;
                    end
                end
            end
            RD_DRAIN: begin
                // Finish only once the last byte has left and nothing is still returning.
                if (fifo_empty && !inflight_q) begin
                    state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                state_d = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    always_comb begin
        occ         = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
        pop         = !fifo_empty && bus.DataReady;
        outstanding = {1'b0, occ} + {2'b00, inflight_q};
        // A read may go out only if its byte is guaranteed a FIFO slot when it lands.
        issue       = (state_q == RD_RUN) && (remaining_q != '0) &&
                      (outstanding < (3'd2 + {2'b00, pop}));

        bus.Busy       = (state_q != RD_IDLE);
        bus.Done       = (state_q == RD_DONE);
        bus.BufClockEn = issue;
        bus.BufWr      = 1'b0;
        bus.BufAddr    = addr_q;
        bus.DataValid  = !fifo_empty;
        bus.DataOut    = fifo_empty ? '0 : fifo_head;
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_page_buf_reader.sv
// Randomized bench for page_buf_reader: a page-buffer model answers reads, and every
// byte, read address and burst timing is compared against the expected burst contents.
module tb_page_buf_reader;
    import flash_ctrl_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    rd_state_e dbg_state;

    always #5 clk = ~clk;

    page_buf_reader_if #(.ADDR_W(BUF_ADDR_W), .DATA_W(BUF_DATA_W)) bus ();

    page_buf_reader #(
        .ADDR_W (BUF_ADDR_W),
        .DATA_W (BUF_DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) dut (
        .Clock     (clk),
        .Reset     (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    logic [7:0]  buf_mem [BUF_DEPTH];
    logic [7:0]  exp_q[$];
    logic [10:0] exp_addr_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc;
    int rdy_mode = 0;
    logic [3:0] toggle_pat = 4'b1001;

    int first_en, first_val, last_val, done_cyc;
    int done_cnt, busy_cnt, issue_cnt, xfer_cnt;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- clock / reset, buffer model, ready generator ----------------
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        bus.BufQ <= (bus.BufClockEn === 1'b1) ? buf_mem[bus.BufAddr] : 8'($urandom);
    end

    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       bus.DataReady = 1'b1;
            1:       bus.DataReady = toggle_pat[cyc % 4];
            default: bus.DataReady = 1'($urandom_range(0, 1));
        endcase
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin : monitor
        logic pop_now;
        int   outstanding;
        pop_now = (bus.DataValid === 1'b1) && (bus.DataReady === 1'b1);
        if (prev_stall) begin
            check_eq("hold_data", {bus.DataValid, bus.DataOut}, {1'b1, prev_data});
        end
        if (bus.BufClockEn === 1'b1) begin
            outstanding = issue_cnt - xfer_cnt;
            check_eq("credit", (outstanding - int'(pop_now)) < 2, 1);
            check_eq("buf_wr", bus.BufWr, 0);
            check_eq("rd_in_burst", exp_addr_q.size() != 0, 1);
            if (exp_addr_q.size() != 0) begin
                check_eq("rd_addr", bus.BufAddr, exp_addr_q.pop_front());
            end
            if (first_en < 0) first_en = cyc;
            issue_cnt++;
        end
        if (pop_now) begin
            check_eq("byte_in_burst", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                check_eq("byte", bus.DataOut, exp_q.pop_front());
            end
            xfer_cnt++;
        end
        if (bus.DataValid === 1'b1) begin
            if (first_val < 0) first_val = cyc;
            last_val = cyc;
        end
        if (bus.Done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.Busy === 1'b1) busy_cnt++;
        prev_stall = (bus.DataValid === 1'b1) && (bus.DataReady === 1'b0);
        prev_data  = bus.DataOut;
    end

    // ---------------- driver tasks ----------------
    task automatic clear_stats();
        exp_q.delete();
        exp_addr_q.delete();
        first_en  = -1;
        first_val = -1;
        last_val  = -1;
        done_cyc  = -1;
        done_cnt  = 0;
        busy_cnt  = 0;
        issue_cnt = 0;
        xfer_cnt  = 0;
    endtask

    task automatic load_expect(input logic [10:0] a, input int n);
        logic [10:0] ai;
        for (int i = 0; i < n; i++) begin
            ai = 11'((int'(a) + i) % BUF_DEPTH);
            exp_addr_q.push_back(ai);
            exp_q.push_back(buf_mem[ai]);
        end
    endtask

    task automatic pulse_start(input logic [10:0] a, input logic [11:0] l);
        @(posedge clk);
        #1;
        bus.Start     = 1'b1;
        bus.StartAddr = a;
        bus.Length    = l;
        start_cyc     = cyc;
        @(posedge clk);
        #1;
        bus.Start     = 1'b0;
        bus.StartAddr = 11'($urandom);
        bus.Length    = 12'($urandom);
    endtask

    task automatic run_burst(input logic [10:0] a, input logic [11:0] l, input int mode,
                             input int dup_at);
        int eff;
        int budget;
        eff = (l > 12'd2048) ? 2048 : int'(l);
        clear_stats();
        load_expect(a, eff);
        rdy_mode = mode;
        pulse_start(a, l);
        budget = 4 * eff + 64;
        for (int k = 0; k < budget && done_cnt == 0; k++) begin
            @(posedge clk);
            #1;
            bus.Start = (k == dup_at);
            if (k == dup_at) begin
                bus.Length    = 12'd3;
                bus.StartAddr = 11'($urandom);
            end
        end
        bus.Start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("done_count", done_cnt, 1);
        check_eq("byte_count", xfer_cnt, eff);
        check_eq("read_count", issue_cnt, eff);
        check_eq("busy_span", busy_cnt, done_cyc - start_cyc);
        if (mode == 0) begin
            check_eq("done_cycle", done_cyc - start_cyc, (eff == 0) ? 1 : eff + 4);
            if (eff > 0) begin
                check_eq("first_read", first_en - start_cyc, 1);
                check_eq("first_valid", first_val - start_cyc, 3);
                check_eq("last_valid", last_val - start_cyc, eff + 2);
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [10:0] ra;
        rst           = 1'b1;
        bus.Start     = 1'b0;
        bus.StartAddr = '0;
        bus.Length    = '0;
        for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] = 8'($urandom);
        clear_stats();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", bus.Busy, 0);
        check_eq("rst_done", bus.Done, 0);
        check_eq("rst_valid", bus.DataValid, 0);
        check_eq("rst_clken", bus.BufClockEn, 0);
        check_eq("rst_bufwr", bus.BufWr, 0);
        check_eq("rst_addr", bus.BufAddr, 0);
        check_eq("rst_dout", bus.DataOut, 0);
        check_eq("rst_state", dbg_state, RD_IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Known four-byte burst from address 0
        buf_mem[0] = 8'd11;
        buf_mem[1] = 8'd22;
        buf_mem[2] = 8'd33;
        buf_mem[3] = 8'd44;
        run_burst(11'd0, 12'd4, 0, -1);

        // Address wrap at the top of the page
        run_burst(11'd2046, 12'd4, 0, -1);

        // Stalling consumer 1,0,0,1
        run_burst(11'($urandom), 12'd16, 1, -1);

        // Zero-length request
        run_burst(11'($urandom), 12'd0, 0, -1);

        // Second Start while busy is ignored
        run_burst(11'($urandom), 12'd20, 0, 2);

        // Over-long request clamps to one page
        run_burst(11'($urandom), 12'($urandom_range(2049, 4095)), 0, -1);

        // Random bursts, random consumer
        for (int n = 0; n < 6; n++) begin
            run_burst(11'($urandom), 12'($urandom_range(1, 40)), 2, -1);
        end
        run_burst(11'($urandom), 12'($urandom_range(1, 40)), 0, -1);

        // Reset in the middle of a burst
        ra = 11'($urandom);
        clear_stats();
        load_expect(ra, 10);
        rdy_mode = 0;
        pulse_start(ra, 12'd10);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_stats();
        @(negedge clk);
        check_eq("abort_busy", bus.Busy, 0);
        check_eq("abort_done", bus.Done, 0);
        check_eq("abort_valid", bus.DataValid, 0);
        check_eq("abort_clken", bus.BufClockEn, 0);
        check_eq("abort_addr", bus.BufAddr, 0);
        check_eq("abort_dout", bus.DataOut, 0);
        check_eq("abort_state", dbg_state, RD_IDLE);
        repeat (12) @(posedge clk);
        #1;
        check_eq("abort_no_done", done_cnt, 0);
        check_eq("abort_no_bytes", xfer_cnt, 0);
        check_eq("abort_no_reads", issue_cnt, 0);

        run_burst(11'($urandom), 12'($urandom_range(5, 30)), 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
